// File: rtl/set_ctrl_guarded_pkg.sv
// Shared types and defaults for the guarded slow-device settings register.
// Flag bit positions match the order of the flags field on the address bus.
package set_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED    = 2'd0,
        ST_ARMED     = 2'd1,
        ST_PENDING   = 2'd2,
        ST_PROBATION = 2'd3
    } state_t;

    localparam logic [7:0] DEF_KEY         = 8'hA5;
    localparam logic [6:0] DEF_RST_FLAGS   = 7'h7B;
    localparam logic [3:0] DEF_RST_TIMEOUT = 4'h3;

    localparam int FLG_IACK     = 6;
    localparam int FLG_VIA      = 5;
    localparam int FLG_IWM      = 4;
    localparam int FLG_SCC      = 3;
    localparam int FLG_SCSI     = 2;
    localparam int FLG_SND      = 1;
    localparam int FLG_CLKGATE  = 0;

    // Counter width that stays at least one bit even for a zero count.
    function automatic int cnt_width(input int max_count);
        return (max_count > 0) ? $clog2(max_count + 1) : 1;
    endfunction

endpackage

// File: rtl/set_ctrl_guarded_wr_strobe.sv
// Turns a (possibly long) settings-write bus cycle into a single one-CLK wr pulse,
// and holds the address captured while the request was active.
module set_wr_strobe #(
    parameter int AW = 11
) (
    input  logic          CLK,
    input  logic          nPOR,
    input  logic          BACT,
    input  logic          SetCSWR,
    input  logic [AW-1:0] A,
    output logic          wr,
    output logic [AW-1:0] a_r
);

    logic req;
    logic req_r;
    logic req_q;

    assign req = BACT && SetCSWR;

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            req_r <= 1'b0;
            req_q <= 1'b0;
            a_r   <= '0;
        end else begin
            req_r <= req;
            req_q <= req_r;
            if (req) begin
                a_r <= A;
            end
        end
    end

    // Rising edge of the registered request; a_r is stable by the time this fires.
    assign wr = req_r && !req_q;

endmodule

// File: rtl/set_ctrl_guarded.sv
// Guarded settings register: key arms a write window, data is applied at bus idle,
// and applied values must be confirmed by a second key write before enough Ticks elapse.
module set_ctrl_guarded
    import set_pkg::*;
#(
    parameter int                 NCH           = 7,
    parameter int                 TW            = 4,
    parameter logic [NCH-1:0]     RST_FLAGS     = DEF_RST_FLAGS,
    parameter logic [TW-1:0]      RST_TIMEOUT   = DEF_RST_TIMEOUT,
    parameter int                 KEYW          = 8,
    parameter logic [KEYW-1:0]    KEY           = DEF_KEY,
    parameter int                 ARM_WIN       = 32,
    parameter int                 CONFIRM_TICKS = 16
) (
    input  logic                  CLK,
    input  logic                  nPOR,
    input  logic                  BACT,
    input  logic                  SetCSWR,
    input  logic [NCH+TW-1:0]     A,
    input  logic                  Tick,
    output logic [NCH-1:0]        SlowFlags,
    output logic [TW-1:0]         SlowTimeout,
    output logic                  Armed,
    output logic                  Probation,
    output state_t                state
);

    localparam int AW = NCH + TW;
    localparam int WW = cnt_width(ARM_WIN);
    localparam int CW = cnt_width(CONFIRM_TICKS);

    localparam logic [WW-1:0] WIN_INIT  = WW'(ARM_WIN);
    localparam logic [WW-1:0] WIN_ONE   = WW'(1);
    localparam logic [CW-1:0] CONF_INIT = CW'(CONFIRM_TICKS);
    localparam logic [CW-1:0] CONF_ONE  = CW'(1);

    generate
        if (KEYW > AW) begin : g_bad_keyw
            $error("set_ctrl_guarded: KEYW exceeds address field width");
        end
    endgenerate

    logic            wr;
    logic [AW-1:0]   a_r;
    logic            key_hit;

    logic [AW-1:0]   staged;
    logic [NCH-1:0]  com_flags;
    logic [TW-1:0]   com_timeout;
    logic [WW-1:0]   win;
    logic [CW-1:0]   conf;

    set_wr_strobe #(
        .AW (AW)
    ) u_strobe (
        .CLK     (CLK),
        .nPOR    (nPOR),
        .BACT    (BACT),
        .SetCSWR (SetCSWR),
        .A       (A),
        .wr      (wr),
        .a_r     (a_r)
    );

    assign key_hit = (a_r[KEYW-1:0] == KEY);

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state       <= ST_LOCKED;
            staged      <= '0;
            win         <= '0;
            conf        <= '0;
            SlowFlags   <= RST_FLAGS;
            SlowTimeout <= RST_TIMEOUT;
            com_flags   <= RST_FLAGS;
            com_timeout <= RST_TIMEOUT;
            Armed       <= 1'b0;
            Probation   <= 1'b0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (wr && key_hit) begin
                        state <= ST_ARMED;
                        win   <= WIN_INIT;
                        Armed <= 1'b1;
                    end
                end

                // A write on the final window cycle is still accepted.
                ST_ARMED: begin
                    if (wr) begin
                        staged <= a_r;
                        state  <= ST_PENDING;
                        win    <= '0;
                        Armed  <= 1'b0;
                    end else if (win == WIN_ONE) begin
                        state  <= ST_LOCKED;
                        win    <= '0;
                        Armed  <= 1'b0;
                    end else if (win != '0) begin
                        win    <= win - 1'b1;
                    end
                end

                ST_PENDING: begin
                    if (!BACT) begin
                        SlowFlags   <= staged[NCH-1:0];
                        SlowTimeout <= staged[AW-1:NCH];
                        if (CONFIRM_TICKS == 0) begin
                            com_flags   <= staged[NCH-1:0];
                            com_timeout <= staged[AW-1:NCH];
                            state       <= ST_LOCKED;
                        end else begin
                            conf      <= CONF_INIT;
                            state     <= ST_PROBATION;
                            Probation <= 1'b1;
                        end
                    end
                end

                // Confirmation is checked before the Tick so a coincident key write wins.
                ST_PROBATION: begin
                    if (wr && key_hit) begin
                        com_flags   <= SlowFlags;
                        com_timeout <= SlowTimeout;
                        conf        <= '0;
                        state       <= ST_LOCKED;
                        Probation   <= 1'b0;
                    end else if (Tick) begin
                        if (conf == CONF_ONE) begin
                            SlowFlags   <= com_flags;
                            SlowTimeout <= com_timeout;
                            conf        <= '0;
                            state       <= ST_LOCKED;
                            Probation   <= 1'b0;
                        end else if (conf != '0) begin
                            conf <= conf - 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= ST_LOCKED;
                    Armed     <= 1'b0;
                    Probation <= 1'b0;
                end
            endcase
        end
    end

endmodule
